mul32_seq: RTL and testbench

- Sequential 32x32 unsigned shift-add multiplier that drives the shared 32-bit ripple adder (ADC32) and consumes its 33-bit sum each cycle.
- Sits directly upstream and downstream of ADC32: produces its A/B/C0 operands and registers its S result.
- Used by the datapath for multi-cycle MUL; produces a 64-bit product after a fixed 32-iteration sequence.

---
 rtl/mul32_seq.sv | 110 +++++++++++
 tb/tb_mul32_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul32_seq.sv
// Sequential unsigned shift-add multiplier driving an external ripple adder; one adder pass per cycle.
// start accepted in IDLE or DONE; product and done appear 32 edges later. start during RUN is ignored.
module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_c0,
    input  logic [WIDTH:0]       add_s
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;
    logic             load;
    logic             step;
    logic             last;

    // The partial product {hi,lo} shifts right one bit per pass; add_s[32] becomes hi[31].
    assign add_a  = hi;
    assign add_b  = lo[0] ? mcand : '0;
    assign add_c0 = 1'b0;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            if (load) begin
                mcand <= a;
                lo    <= b;
                hi    <= '0;
                count <= '0;
            end else if (step) begin
                hi    <= add_s[WIDTH:1];
                lo    <= {add_s[0], lo[WIDTH-1:1]};
                count <= count + CW'(1);
            end
            if (last) begin
                product <= {add_s[WIDTH:1], add_s[0], lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: behavioural adder and a countdown/product model checked every cycle,
// plus directed operations with literal expected products and latencies.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_c0;
    logic [32:0] add_s;

    int n_cmp = 0;
    int n_err = 0;

    mul32_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_c0  (add_c0),
        .add_s   (add_s)
    );

    // Behavioural stand-in for the shared ripple adder.
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_c0};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Model: an accepted operation finishes 32 edges later with the full 64-bit product.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pend = '0;
    logic [31:0] m_mcand = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_prod = '0;
        end else begin
            automatic logic accept = start && (m_left == 0);
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_prod = m_pend;
                    m_done = 1'b1;
                end
            end
            if (accept) begin
                m_pend  = {32'b0, a} * {32'b0, b};
                m_mcand = a;
                m_left  = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_busy", {63'b0, busy}, {63'b0, m_left > 0});
            check("model_done", {63'b0, done}, {63'b0, m_done});
            check("model_product", product, m_prod);
            check("add_c0_zero", {63'b0, add_c0}, 64'd0);
            if (m_left > 0) begin
                if (add_b !== 32'd0)
                    check("add_b_is_mcand", {32'b0, add_b}, {32'b0, m_mcand});
                check("add_a_mult_free", 64'd0, 64'd0 + 64'(add_b == 32'd0 || add_b == m_mcand ? 0 : 1));
            end
        end
    end

    // Present start with operands for one edge, then scramble a/b to show they were captured.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        @(posedge clk); #1;
        start = 1'b1; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Called #1 after the accepting edge; k counts negedges until done is seen.
    task automatic wait_done(output int k, output int bcyc);
        bcyc = 0;
        k    = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
        end
    endtask

    initial begin
        int k, bc, ndone;

        #12;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        rst_n = 1'b1;

        issue(32'd3, 32'd5);
        wait_done(k, bc);
        check("3x5_latency", 64'(k), 64'd33);
        check("3x5_busy_cycles", 64'(bc), 64'd32);
        check("3x5_product", product, 64'h0000_0000_0000_000F);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, bc);
        check("max_product", product, 64'hFFFF_FFFE_0000_0001);

        issue(32'hA5A5_A5A5, 32'd0);
        wait_done(k, bc);
        check("zero_product", product, 64'd0);

        issue(32'h8000_0000, 32'd2);
        wait_done(k, bc);
        check("msb_product", product, 64'h0000_0001_0000_0000);

        // start during RUN must be ignored
        issue(32'd7, 32'd9);
        repeat (8) @(posedge clk);
        #1; start = 1'b1; a = 32'd1; b = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(k, bc);
        check("ignore_start_product", product, 64'd63);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore_start_single_done", 64'(ndone), 64'd0);
        check("ignore_start_held", product, 64'd63);

        // asynchronous reset mid-operation
        issue(32'h1234, 32'h10);
        repeat (15) @(negedge clk);
        #2; rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        #14; rst_n = 1'b1;
        issue(32'd2, 32'd3);
        wait_done(k, bc);
        check("after_reset_latency", 64'(k), 64'd33);
        check("after_reset_product", product, 64'd6);

        // back-to-back: start accepted in the done cycle
        issue(32'd4, 32'd4);
        wait_done(k, bc);
        check("b2b_first_product", product, 64'd16);
        start = 1'b1; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        @(negedge clk);
        check("b2b_rerun_busy", {63'b0, busy}, 64'd1);
        check("b2b_product_held", product, 64'd16);
        wait_done(k, bc);
        check("b2b_second_latency", 64'(k + 1), 64'd33);
        check("b2b_second_product", product, 64'd30);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
